// File: rtl/xphy_link_ctrl.sv
// xphy_link_ctrl: per-channel 10GBASE-R link qualification FSM, MAC core resets and XGMII pipeline.
// Define XPHY_LINK_DROP_CNT_EN to build the saturating per-channel link-drop counters.
module xphy_link_ctrl #(
    parameter int C_NUM_CH = 1,
    parameter int C_HOLD_W = 16,
    parameter int C_PIPE   = 1
) (
    input  logic                    clk156,
    input  logic                    reset,
    input  logic [C_NUM_CH-1:0]     tx_resetdone,
    input  logic [C_NUM_CH-1:0]     rx_resetdone,
    input  logic [C_NUM_CH-1:0]     tx_fault,
    input  logic [C_NUM_CH-1:0]     signal_detect,
    input  logic [64*C_NUM_CH-1:0]  xgmii_txd,
    input  logic [8*C_NUM_CH-1:0]   xgmii_txc,
    output logic [64*C_NUM_CH-1:0]  xgmii_txd_int,
    output logic [8*C_NUM_CH-1:0]   xgmii_txc_int,
    input  logic [64*C_NUM_CH-1:0]  xgmii_rxd_int,
    input  logic [8*C_NUM_CH-1:0]   xgmii_rxc_int,
    output logic [64*C_NUM_CH-1:0]  xgmii_rxd,
    output logic [8*C_NUM_CH-1:0]   xgmii_rxc,
    output logic [C_NUM_CH-1:0]     resetdone,
    output logic [C_NUM_CH-1:0]     core_reset_tx,
    output logic [C_NUM_CH-1:0]     core_reset_rx,
    output logic [C_NUM_CH-1:0]     link_up,
    output logic [8*C_NUM_CH-1:0]   link_drop_cnt
);
    localparam int TW = 72*C_NUM_CH;
    localparam logic [C_HOLD_W-1:0] HOLD_TERM = {{(C_HOLD_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_RST, S_WAIT, S_HOLD, S_UP} state_t;

    (* async_reg = "true" *) logic [4*C_NUM_CH-1:0] sync1_q;
    (* async_reg = "true" *) logic [4*C_NUM_CH-1:0] sync2_q;
    logic [C_NUM_CH-1:0] crx_d;

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {signal_detect, tx_fault, rx_resetdone, tx_resetdone};
            sync2_q <= sync1_q;
        end
    end

    assign resetdone = sync2_q[C_NUM_CH-1:0] & sync2_q[2*C_NUM_CH-1:C_NUM_CH];

    for (genvar c = 0; c < C_NUM_CH; c++) begin : g_ch
        state_t              state_q, state_d;
        logic [C_HOLD_W-1:0] cnt_q, cnt_d;
        logic                ok, crx_q, ctx_q, up_q;

        assign ok = sync2_q[c] & sync2_q[C_NUM_CH+c] & ~sync2_q[2*C_NUM_CH+c] & sync2_q[3*C_NUM_CH+c];

        // losing ok wins over reaching the hold-off terminal count
        always_comb begin
            state_d = (state_q == S_RST || !ok) ? S_WAIT :
                      (state_q == S_WAIT) ? S_HOLD :
                      (state_q == S_HOLD && cnt_q == HOLD_TERM) ? S_UP : state_q;
            cnt_d   = (state_q == S_HOLD && ok) ? cnt_q + C_HOLD_W'(1) : '0;
        end

        assign crx_d[c] = !(state_d == S_HOLD || state_d == S_UP);

        always_ff @(posedge clk156 or posedge reset) begin
            if (reset) begin
                state_q <= S_RST;
                cnt_q   <= '0;
                crx_q   <= 1'b1;
                ctx_q   <= 1'b1;
                up_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                crx_q   <= crx_d[c];
                ctx_q   <= state_d != S_UP;
                up_q    <= state_d == S_UP;
            end
        end

        assign core_reset_rx[c] = crx_q;
        assign core_reset_tx[c] = ctx_q;
        assign link_up[c]       = up_q;

`ifdef XPHY_LINK_DROP_CNT_EN
        logic [7:0] drop_q;

        always_ff @(posedge clk156 or posedge reset) begin
            if (reset) begin
                drop_q <= '0;
            end else if (state_q == S_UP && !ok && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end

        assign link_drop_cnt[8*c +: 8] = drop_q;
`else
        assign link_drop_cnt[8*c +: 8] = 8'h00;
`endif
    end

    // each chain is {stages, input}; stage k loads chain slice k, the top slice is the output
    logic [C_PIPE*TW-1:0]     tx_q, rx_q, rx_d;
    logic [(C_PIPE+1)*TW-1:0] tx_chain, rx_chain;

    assign tx_chain = {tx_q, xgmii_txc, xgmii_txd};
    assign rx_chain = {rx_q, xgmii_rxc_int, xgmii_rxd_int};

    always_comb begin
        rx_d = rx_chain[C_PIPE*TW-1:0];
        for (int k = 0; k < C_NUM_CH; k++) begin
            if (crx_d[k]) begin
                rx_d[(C_PIPE-1)*TW + 64*k +: 64]             = {8{8'h07}};
                rx_d[(C_PIPE-1)*TW + 64*C_NUM_CH + 8*k +: 8] = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk156) begin
        tx_q <= tx_chain[C_PIPE*TW-1:0];
        rx_q <= rx_d;
    end

    assign {xgmii_txc_int, xgmii_txd_int} = tx_chain[(C_PIPE+1)*TW-1 -: TW];
    assign {xgmii_rxc, xgmii_rxd}         = rx_chain[(C_PIPE+1)*TW-1 -: TW];
endmodule
